fft8_seq_ctrl: RTL and testbench
================================

# fft8_seq_ctrl

Time-multiplexed sequencer for an 8-point radix-2 DIT FFT in IEEE-754 single precision. It accepts one frame of 8 complex samples as a stream, stores them in bit-reversed order in an internal 8-entry complex register file, and schedules 12 butterflies (3 stages × 4) through one external butterfly instance. It then streams the 8 results out in natural order. It replaces the fully unrolled 12-butterfly array when area matters more than throughput.

## Interface
- `TW1_RE`, default `32'h3F3504F3`: real part of W1 (+0.70710677); `TW1_IM` is its negation, `32'hBF3504F3`.
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: input sample valid.
- `in_ready`, output, 1: controller can accept a sample.
- `in_re`, `in_im`, input, 32 each: input sample in float32.
- `out_valid`, output, 1: output sample valid.
- `out_ready`, input, 1: downstream accepts the sample.
- `out_re`, `out_im`, output, 32 each: output bin in float32.
- `out_last`, output, 1: high with bin 7.
- `busy`, output, 1: high when state ≠ LOAD.
- `bf_xr`, `bf_xi`, `bf_yr`, `bf_yi`, output, 32 each: butterfly operands x (top) and y (bottom).
- `bf_wr`, `bf_wi`, output, 32 each: twiddle factor for the butterfly.
- `bf_x0r`, `bf_x0i`, `bf_x1r`, `bf_x1i`, input, 32 each: butterfly results.
  - x0 = x + w·y and x1 = x − w·y, with (w·y)re = wr·yr − wi·yi and (w·y)im = wr·yi + wi·yr.
  - The butterfly is combinational; results are valid in the same cycle the operands are driven.

## Operation
- States: LOAD, COMPUTE, UNLOAD. Counters: `in_cnt`[2:0], `stg`[1:0] (0..2), `bf`[1:0], `out_cnt`[2:0].
- Register file is 8 × {re, im} × 32 bits. It is not reset.
- LOAD:
  - `in_ready` = 1.
  - On each handshake (in_valid & in_ready), write the sample to address bitrev3(in_cnt), then increment `in_cnt`.
  - On the 8th handshake, go to COMPUTE with `stg` = 0 and `bf` = 0.
  - Gaps in in_valid stall the load without loss.
- COMPUTE: one butterfly per cycle, with no stalls. Index pairs (top, bottom) and twiddles per stage:
  - stg 0: (0,1), (2,3), (4,5), (6,7); all W0.
  - stg 1: (0,2), (1,3), (4,6), (5,7); W0, W2, W0, W2.
  - stg 2: (0,4), (1,5), (2,6), (3,7); W0, W1, W2, W3.
  - In general, span = 1 << stg; top = ((bf >> stg) << (stg+1)) | (bf & (span−1)); bottom = top + span.
  - Twiddle index = (bf & (span−1)) << (2−stg).
  - Twiddle values: W0 = (3F800000, 00000000); W1 = (TW1_RE, TW1_IM); W2 = (00000000, BF800000); W3 = (BF3504F3, BF3504F3).
  - Each cycle: drive bf_x* from file[top] and bf_y* from file[bottom]. At the clock edge, write x0 back to top and x1 back to bottom (in-place).
  - After stg 2, bf 3: go to UNLOAD with `out_cnt` = 0.
- UNLOAD:
  - out_valid = 1; out_re/out_im = file[out_cnt]; out_last = (out_cnt == 7).
  - On each handshake, increment `out_cnt`. On the handshake with out_last set, go to LOAD with `in_cnt` = 0.
- When state ≠ COMPUTE, bf_* outputs are 0 and the bf_x0*/bf_x1* results are ignored.
- No arithmetic or rounding happens in this block; all float math is in the butterfly.

## Timing
- Reset (rst_n low at a clock edge): state = LOAD, all counters 0.
  - From the following cycle: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, bf_* = 0.
  - out_re/out_im are don't-care while out_valid = 0.
- Reset overrides any state, including mid-LOAD, mid-COMPUTE or mid-UNLOAD. The partial frame is discarded, and no output handshake is produced for it.
- Handshake rules:
  - A handshake occurs on a rising edge where valid & ready.
  - in_ready and out_valid are decoded from state only; they never depend combinationally on in_valid or out_ready.
  - While out_valid = 1 and out_ready = 0, out_re, out_im and out_last hold stable.
- Latency:
  - COMPUTE lasts exactly 12 cycles.
  - The first out_valid is asserted 12 cycles after the edge carrying the 8th input handshake.
  - Minimum frame period is 28 cycles (8 load + 12 compute + 8 unload).
- in_ready = 0 throughout COMPUTE and UNLOAD. No overlap between frames.
- in_ready rises in the cycle after the edge carrying the out_last handshake.

## Test plan
- Impulse x0 = 1.0 (3F800000), others 0 → all 8 bins re = 3F800000, im = ±0; out_last only on bin 7.
- DC input, all re = 1.0 → bin 0 re = 41000000 (8.0); bins 1–7 compare equal to 0.0 (±0 both accepted).
- Impulse at x1 = 1.0 → bin k = W^k:
  - bin 1 = (3F3504F3, BF3504F3); bin 2 = (0, −1.0); bin 4 = (BF800000, 0).
  - 12 cycles of bf activity, with each top/bottom pair matching the schedule above.
- Backpressure and gaps:
  - Random in_valid gaps and out_ready held low for 5 cycles on bin 3 → identical results.
  - Output data holds during the stall; no duplicated or lost beats.
- rst_n low for 1 cycle during COMPUTE cycle 6 → next cycle in_ready = 1 and out_valid = 0; a fresh impulse frame then yields the correct all-ones response.
- Two back-to-back frames with in_valid and out_ready tied high → 28-cycle period; the second frame's results are independent of the first.

Source files
------------

// File: rtl/fft8_seq_ctrl_if.sv
// Stream, status and butterfly-operand bundle for the 8-point FFT sequencer.
// slave is the controller's view; master is the surrounding datapath/environment.
interface fft8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic        out_last;
  logic        busy;
  logic [31:0] bf_xr;
  logic [31:0] bf_xi;
  logic [31:0] bf_yr;
  logic [31:0] bf_yi;
  logic [31:0] bf_wr;
  logic [31:0] bf_wi;
  logic [31:0] bf_x0r;
  logic [31:0] bf_x0i;
  logic [31:0] bf_x1r;
  logic [31:0] bf_x1i;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
           bf_x0r, bf_x0i, bf_x1r, bf_x1i,
    output in_ready, out_valid, out_re, out_im, out_last, busy,
           bf_xr, bf_xi, bf_yr, bf_yi, bf_wr, bf_wi
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
           bf_x0r, bf_x0i, bf_x1r, bf_x1i,
    input  in_ready, out_valid, out_re, out_im, out_last, busy,
           bf_xr, bf_xi, bf_yr, bf_yi, bf_wr, bf_wi
  );
endinterface

// File: rtl/fft8_seq_ctrl.sv
// Time-multiplexed 8-point radix-2 DIT FFT sequencer: bit-reversed load, 12 in-place
// butterflies through one external combinational butterfly, natural-order unload.
module fft8_seq_ctrl #(
  parameter logic [31:0] TW1_RE = 32'h3F3504F3,
  parameter logic [31:0] TW1_IM = 32'hBF3504F3
) (
  input  logic           clk,
  input  logic           rst_n,
  fft8_seq_ctrl_if.slave io
);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;

  state_e      state_q;
  logic [2:0]  in_cnt_q;
  logic [2:0]  out_cnt_q;
  logic [1:0]  stg_q;
  logic [1:0]  bf_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        busy_q;

  logic [31:0] re_q [8];
  logic [31:0] im_q [8];

  logic [2:0]  top_idx;
  logic [2:0]  bot_idx;
  logic [1:0]  tw_idx;
  logic [31:0] tw_re;
  logic [31:0] tw_im;
  logic [2:0]  wr_addr;
  logic        computing;

  assign computing = (state_q == COMPUTE);
  assign wr_addr   = {in_cnt_q[0], in_cnt_q[1], in_cnt_q[2]};

  // Closed-form pair/twiddle indices: the stage's span bit is inserted into bf.
  always_comb begin
    top_idx = '0;
    bot_idx = '0;
    tw_idx  = '0;
    unique case (stg_q)
      2'd0: begin
        top_idx = {bf_q, 1'b0};
        bot_idx = {bf_q, 1'b1};
        tw_idx  = 2'd0;
      end
      2'd1: begin
        top_idx = {bf_q[1], 1'b0, bf_q[0]};
        bot_idx = {bf_q[1], 1'b1, bf_q[0]};
        tw_idx  = {bf_q[0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, bf_q};
        bot_idx = {1'b1, bf_q};
        tw_idx  = bf_q;
      end
    endcase
  end

  always_comb begin
    tw_re = 32'h3F800000;
    tw_im = 32'h00000000;
    unique case (tw_idx)
      2'd0: begin tw_re = 32'h3F800000; tw_im = 32'h00000000; end
      2'd1: begin tw_re = TW1_RE;       tw_im = TW1_IM;       end
      2'd2: begin tw_re = 32'h00000000; tw_im = 32'hBF800000; end
      default: begin tw_re = 32'hBF3504F3; tw_im = 32'hBF3504F3; end
    endcase
  end

  assign io.bf_xr = computing ? re_q[top_idx] : '0;
  assign io.bf_xi = computing ? im_q[top_idx] : '0;
  assign io.bf_yr = computing ? re_q[bot_idx] : '0;
  assign io.bf_yi = computing ? im_q[bot_idx] : '0;
  assign io.bf_wr = computing ? tw_re : '0;
  assign io.bf_wi = computing ? tw_im : '0;

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.busy      = busy_q;
  assign io.out_re    = re_q[out_cnt_q];
  assign io.out_im    = im_q[out_cnt_q];

  // Register file is deliberately unreset; a discarded frame leaves stale data only.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && io.in_valid) begin
      re_q[wr_addr] <= io.in_re;
      im_q[wr_addr] <= io.in_im;
    end else if (computing) begin
      re_q[top_idx] <= io.bf_x0r;
      im_q[top_idx] <= io.bf_x0i;
      re_q[bot_idx] <= io.bf_x1r;
      im_q[bot_idx] <= io.bf_x1i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      stg_q       <= '0;
      bf_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (io.in_valid) begin
            in_cnt_q <= in_cnt_q + 3'd1;
            if (in_cnt_q == 3'd7) begin
              state_q    <= COMPUTE;
              stg_q      <= '0;
              bf_q       <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          bf_q <= bf_q + 2'd1;
          if (bf_q == 2'd3) begin
            if (stg_q == 2'd2) begin
              state_q     <= UNLOAD;
              out_cnt_q   <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end else begin
              stg_q <= stg_q + 2'd1;
            end
          end
        end
        UNLOAD: begin
          if (io.out_ready) begin
            out_cnt_q  <= out_cnt_q + 3'd1;
            out_last_q <= (out_cnt_q == 3'd6);
            if (out_cnt_q == 3'd7) begin
              state_q     <= LOAD;
              in_cnt_q    <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Bench for fft8_seq_ctrl: float32 butterfly model, directed frame table, and
// hand sequences for reset-during-compute and back-to-back frames.
module tb_fft8_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft8_seq_ctrl_if io ();

  fft8_seq_ctrl #(.TW1_RE(32'h3F3504F3), .TW1_IM(32'hBF3504F3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    e = {3'b000, b[30:23]} + 11'd896;
    if (b[30:23] == 8'd0) d = {b[31], 63'd0};
    else                  d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [30:0] v;
    logic        rnd;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e   = d[62:52] - 11'd896;
    rnd = d[28] && ((d[27:0] != 28'd0) || d[29]);
    v   = {e[7:0], d[51:29]} + {30'd0, rnd};
    return {d[63], v};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction
  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  // External butterfly: x0 = x + w*y, x1 = x - w*y, each op rounded to float32.
  logic [31:0] bf_pr, bf_pi;
  always_comb begin
    bf_pr     = fsub(fmul(io.bf_wr, io.bf_yr), fmul(io.bf_wi, io.bf_yi));
    bf_pi     = fadd(fmul(io.bf_wr, io.bf_yi), fmul(io.bf_wi, io.bf_yr));
    io.bf_x0r = fadd(io.bf_xr, bf_pr);
    io.bf_x0i = fadd(io.bf_xi, bf_pi);
    io.bf_x1r = fsub(io.bf_xr, bf_pr);
    io.bf_x1i = fsub(io.bf_xi, bf_pi);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Float compare where +0 and -0 are equal.
  task automatic chkf(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!((act === exp) || (act[30:0] == 31'd0 && exp[30:0] == 31'd0))) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0][31:0] in_re;
    logic [7:0][31:0] in_im;
    logic [7:0][31:0] exp_re;
    logic [7:0][31:0] exp_im;
    logic             gaps;
    logic [3:0]       stall_bin;
    logic [3:0]       stall_len;
  } vec_t;

  vec_t vecs [4];

  int          brv     [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          sch_top [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int          sch_bot [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int          sch_tw  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  logic [31:0] w_re    [4]  = '{32'h3F800000, 32'h3F3504F3, 32'h00000000, 32'hBF3504F3};
  logic [31:0] w_im    [4]  = '{32'h00000000, 32'hBF3504F3, 32'hBF800000, 32'hBF3504F3};

  logic [31:0] m_re [8];
  logic [31:0] m_im [8];

  function automatic logic [31:0] bf_or();
    return io.bf_xr | io.bf_xi | io.bf_yr | io.bf_yi | io.bf_wr | io.bf_wi;
  endfunction

  task automatic run_frame(input vec_t v, input int vi);
    int i, guard, k, stall_left;
    logic rdy, cur_last, hold_last;
    logic [31:0] cur_re, cur_im, hold_re, hold_im, pr, pi;
    logic [31:0] got_re [8];
    logic [31:0] got_im [8];
    int t, b, w;
    i = 0; guard = 0;
    while (i < 8 && guard < 400) begin
      @(negedge clk);
      io.in_valid = (v.gaps && ($urandom_range(0, 2) == 0)) ? 1'b0 : 1'b1;
      io.in_re    = v.in_re[i];
      io.in_im    = v.in_im[i];
      rdy         = io.in_ready;
      @(posedge clk);
      if (io.in_valid && rdy) begin
        m_re[brv[i]] = v.in_re[i];
        m_im[brv[i]] = v.in_im[i];
        i++;
      end
      guard++;
    end
    if (i < 8) chk($sformatf("v%0d_load_timeout", vi), 64'(i), 64'd8);
    @(negedge clk);
    io.in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      t = sch_top[c]; b = sch_bot[c]; w = sch_tw[c];
      chk($sformatf("v%0d_c%0d_ctrl", vi, c), {61'd0, io.busy, io.in_ready, io.out_valid}, 64'd4);
      chk($sformatf("v%0d_c%0d_x", vi, c), {io.bf_xr, io.bf_xi}, {m_re[t], m_im[t]});
      chk($sformatf("v%0d_c%0d_y", vi, c), {io.bf_yr, io.bf_yi}, {m_re[b], m_im[b]});
      chk($sformatf("v%0d_c%0d_w", vi, c), {io.bf_wr, io.bf_wi}, {w_re[w], w_im[w]});
      pr = fsub(fmul(w_re[w], m_re[b]), fmul(w_im[w], m_im[b]));
      pi = fadd(fmul(w_re[w], m_im[b]), fmul(w_im[w], m_re[b]));
      m_re[b] = fsub(m_re[t], pr);
      m_im[b] = fsub(m_im[t], pi);
      m_re[t] = fadd(m_re[t], pr);
      m_im[t] = fadd(m_im[t], pi);
      @(negedge clk);
    end
    chk($sformatf("v%0d_first_out_valid", vi), {63'd0, io.out_valid}, 64'd1);
    k = 0; guard = 0; stall_left = int'(v.stall_len);
    hold_re = '0; hold_im = '0; hold_last = 1'b0;
    while (k < 8 && guard < 200) begin
      cur_re = io.out_re; cur_im = io.out_im; cur_last = io.out_last;
      if (k == int'(v.stall_bin)) begin
        if (stall_left == int'(v.stall_len)) begin
          hold_re = cur_re; hold_im = cur_im; hold_last = cur_last;
        end else begin
          chk($sformatf("v%0d_stall_hold", vi), {cur_re, cur_im[31:1], cur_last},
              {hold_re, hold_im[31:1], hold_last});
        end
      end
      if (k == int'(v.stall_bin) && stall_left > 0) begin
        io.out_ready = 1'b0;
        stall_left--;
      end else begin
        io.out_ready = 1'b1;
      end
      if (k == 0) chk($sformatf("v%0d_bf_idle", vi), {32'd0, bf_or()}, 64'd0);
      rdy = io.out_valid;
      @(posedge clk);
      if (io.out_ready && rdy) begin
        got_re[k] = cur_re; got_im[k] = cur_im;
        chk($sformatf("v%0d_last_b%0d", vi, k), {63'd0, cur_last}, {63'd0, k == 7});
        k++;
      end
      @(negedge clk);
      guard++;
    end
    if (k < 8) chk($sformatf("v%0d_unload_timeout", vi), 64'(k), 64'd8);
    chk($sformatf("v%0d_post_ctrl", vi),
        {60'd0, io.in_ready, io.out_valid, io.busy, io.out_last}, 64'd8);
    for (int n = 0; n < k; n++) begin
      chk($sformatf("v%0d_model_b%0d", vi, n), {got_re[n], got_im[n]}, {m_re[n], m_im[n]});
      chkf($sformatf("v%0d_re_b%0d", vi, n), got_re[n], v.exp_re[n]);
      chkf($sformatf("v%0d_im_b%0d", vi, n), got_im[n], v.exp_im[n]);
    end
  endtask

  initial begin
    logic [31:0] bb_re [16];
    logic [31:0] bb_im [16];
    logic [31:0] fr [16];
    int s, r, t_in0, t_in1, t_last0, t_last1, guard;
    logic rdy, ov, ol;
    logic [31:0] ore, oim;

    // x0 impulse -> flat unit spectrum
    vecs[0]           = '0;
    vecs[0].in_re[0]  = 32'h3F800000;
    vecs[0].exp_re    = {8{32'h3F800000}};
    vecs[0].stall_bin = 4'd8;
    // DC -> 8.0 at bin 0
    vecs[1]           = '0;
    vecs[1].in_re     = {8{32'h3F800000}};
    vecs[1].exp_re[0] = 32'h41000000;
    vecs[1].stall_bin = 4'd8;
    // x1 impulse -> bin k = W^k (listed bin 7 down to bin 0)
    vecs[2]           = '0;
    vecs[2].in_re[1]  = 32'h3F800000;
    vecs[2].exp_re    = {32'h3F3504F3, 32'h00000000, 32'hBF3504F3, 32'hBF800000,
                         32'hBF3504F3, 32'h00000000, 32'h3F3504F3, 32'h3F800000};
    vecs[2].exp_im    = {32'h3F3504F3, 32'h3F800000, 32'h3F3504F3, 32'h00000000,
                         32'hBF3504F3, 32'hBF800000, 32'hBF3504F3, 32'h00000000};
    vecs[2].stall_bin = 4'd8;
    // same frame with input gaps and a 5-cycle stall on bin 3
    vecs[3]           = vecs[2];
    vecs[3].gaps      = 1'b1;
    vecs[3].stall_bin = 4'd3;
    vecs[3].stall_len = 4'd5;

    io.in_valid = 1'b0; io.in_re = '0; io.in_im = '0; io.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {60'd0, io.in_ready, io.out_valid, io.busy, io.out_last}, 64'd8);
    chk("reset_bf", {32'd0, bf_or()}, 64'd0);
    rst_n = 1'b1;

    for (int vi = 0; vi < 4; vi++) run_frame(vecs[vi], vi);

    // reset during compute cycle 6 discards the frame
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1; io.in_re = vecs[2].in_re[i]; io.in_im = vecs[2].in_im[i];
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_busy", {63'd0, io.busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_ctrl", {60'd0, io.in_ready, io.out_valid, io.busy, io.out_last}, 64'd8);
    chk("rst_mid_bf", {32'd0, bf_or()}, 64'd0);
    run_frame(vecs[0], 10);

    // back-to-back frames, DC then x1 impulse, valid/ready tied high
    for (int i = 0; i < 8; i++) begin
      bb_re[i] = vecs[1].in_re[i]; bb_im[i] = vecs[1].in_im[i];
      bb_re[i + 8] = vecs[2].in_re[i]; bb_im[i + 8] = vecs[2].in_im[i];
    end
    s = 0; r = 0; t_in0 = -1; t_in1 = -1; t_last0 = -1; t_last1 = -1; guard = 0;
    io.out_ready = 1'b1;
    while (r < 16 && guard < 200) begin
      @(negedge clk);
      io.in_valid = (s < 16);
      io.in_re    = bb_re[s % 16];
      io.in_im    = bb_im[s % 16];
      rdy = io.in_ready; ov = io.out_valid; ol = io.out_last;
      ore = io.out_re; oim = io.out_im;
      @(posedge clk);
      if (io.in_valid && rdy) begin
        if (s == 0) t_in0 = guard;
        if (s == 8) t_in1 = guard;
        s++;
      end
      if (ov) begin
        fr[r] = (r < 8) ? ore : oim;
        if (r >= 8) chkf($sformatf("b2b_re_b%0d", r - 8), ore, vecs[2].exp_re[r - 8]);
        if (ol && r == 7)  t_last0 = guard;
        if (ol && r == 15) t_last1 = guard;
        r++;
      end
      guard++;
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    if (r < 16) chk("b2b_timeout", 64'(r), 64'd16);
    chk("b2b_in_period", 64'(t_in1 - t_in0), 64'd28);
    chk("b2b_last_period", 64'(t_last1 - t_last0), 64'd28);
    chkf("b2b_dc_bin0", fr[0], 32'h41000000);
    chkf("b2b_dc_bin4", fr[4], 32'h00000000);
    chkf("b2b_x1_bin2_im", fr[10], 32'hBF800000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
